controlador_division: RTL and testbench

- Sequencer for an unsigned N-bit restoring divider. It reuses the team's N-bit subtractor (difference plus negativo/zero flags) as its only arithmetic resource.
- Each CALC cycle it issues one trial subtraction and decides from the negativo flag whether to keep or restore the partial remainder.
- Sits beside the ALU as the multi-cycle DIV/MOD unit, with a start/listo/valido handshake toward the control unit.

---
 rtl/pda_pkg.sv | 20 ++
 rtl/controlador_division_if.sv | 34 +++
 rtl/controlador_division_restador.sv | 29 ++
 rtl/controlador_division.sv | 129 ++++++++++++
 tb/tb_controlador_division.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/pda_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pda_pkg
// Description : Shared types and defaults for the DIV/MOD sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pda_pkg;

   // Default operand/result width of the divider
   localparam int DIV_ANCHO_DEF = 32;

   // Divider sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } estado_div_t;

endpackage : pda_pkg
`default_nettype wire

// File: rtl/controlador_division_if.sv
`default_nettype none
// ============================================================================
// Module      : controlador_division_if
// Description : start/listo/valido handshake and operand/result bus between
//               the control unit (master) and the divider (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface controlador_division_if
   import pda_pkg::*;
#(
   parameter int N = DIV_ANCHO_DEF
);
   logic         start;
   logic [N-1:0] dividendo;
   logic [N-1:0] divisor;
   logic         listo;
   logic         valido;
   logic [N-1:0] cociente;
   logic [N-1:0] residuo;
   logic         div_cero;

   // Control unit side: issues requests, consumes results
   modport master (
      output start, dividendo, divisor,
      input  listo, valido, cociente, residuo, div_cero
   );

   // Divider side
   modport slave (
      input  start, dividendo, divisor,
      output listo, valido, cociente, residuo, div_cero
   );
endinterface : controlador_division_if
`default_nettype wire

// File: rtl/controlador_division_restador.sv
`default_nettype none
// ============================================================================
// Module      : restador_n
// Description : W-bit subtractor, difference plus negativo/cero/overflow flags.
//               negativo is the unsigned borrow (i_a < i_b).
// Revision    : 1.0 - initial release
// ============================================================================
module restador_n #(
   parameter int W = 32
) (
   input  wire logic [W-1:0] i_a,
   input  wire logic [W-1:0] i_b,
   output logic      [W-1:0] o_dif,
   output logic              o_negativo,
   output logic              o_cero,
   output logic              o_desbordamiento
);
   logic w_borrow;

   // One extra bit on the subtraction exposes the borrow out
   assign {w_borrow, o_dif} = {1'b0, i_a} - {1'b0, i_b};
   assign o_negativo        = w_borrow;
   assign o_cero            = (o_dif == '0);
   // Two's-complement overflow: operands of different sign and the result
   // sign differs from the minuend
   assign o_desbordamiento  = (i_a[W-1] ^ i_b[W-1]) & (o_dif[W-1] ^ i_a[W-1]);

endmodule : restador_n
`default_nettype wire

// File: rtl/controlador_division.sv
`default_nettype none
// ============================================================================
// Module      : controlador_division
// Description : Sequencer for an unsigned N-bit restoring divider. One trial
//               subtraction per CALC cycle through a single (N+1)-bit
//               subtractor; the borrow selects keep or restore.
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_division
   import pda_pkg::*;
#(
   parameter int N = DIV_ANCHO_DEF
) (
   input wire logic              clk,
   input wire logic              rst_n,
   controlador_division_if.slave bus
);
   localparam int CW = $clog2(N);

   estado_div_t    r_estado;
   logic [N-1:0]   r_q;
   logic [N-1:0]   r_d;
   logic [N-1:0]   r_r;
   logic [CW-1:0]  r_cnt;
   logic           r_listo;
   logic           r_valido;
   logic [N-1:0]   r_cociente;
   logic [N-1:0]   r_residuo;
   logic           r_div_cero;

   logic [N:0]     w_t;
   logic [N:0]     w_dif;
   logic           w_neg;
   logic           w_cero;
   logic           w_desb;
   logic [N-1:0]   w_r_sig;
   logic [N-1:0]   w_q_sig;
   logic [2:0]     w_unused_flags;

   // Partial remainder shifted left with the next dividend bit appended
   assign w_t = {r_r, r_q[N-1]};

   restador_n #(
      .W (N + 1)
   ) u_restador (
      .i_a              (w_t),
      .i_b              ({1'b0, r_d}),
      .o_dif            (w_dif),
      .o_negativo       (w_neg),
      .o_cero           (w_cero),
      .o_desbordamiento (w_desb)
   );

   // Since R < D always holds, a non-negative difference fits in N bits
   assign w_r_sig = w_neg ? w_t[N-1:0] : w_dif[N-1:0];
   assign w_q_sig = {r_q[N-2:0], ~w_neg};

   // Flags the restoring algorithm never needs
   assign w_unused_flags = {w_cero, w_desb, w_dif[N]};

   // Sequencer FSM, datapath registers and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado   <= IDLE;
         r_q        <= '0;
         r_d        <= '0;
         r_r        <= '0;
         r_cnt      <= '0;
         r_listo    <= 1'b1;
         r_valido   <= 1'b0;
         r_cociente <= '0;
         r_residuo  <= '0;
         r_div_cero <= 1'b0;
      end else begin
         case (r_estado)
            IDLE: begin
               r_valido <= 1'b0;
               if (bus.start) begin
                  r_q     <= bus.dividendo;
                  r_d     <= bus.divisor;
                  r_r     <= '0;
                  r_cnt   <= CW'(N - 1);
                  r_listo <= 1'b0;
                  if (bus.divisor == '0) begin
                     // Skip iterations; publish the fixed divide-by-zero result
                     r_estado   <= DONE;
                     r_valido   <= 1'b1;
                     r_cociente <= '1;
                     r_residuo  <= bus.dividendo;
                     r_div_cero <= 1'b1;
                  end else begin
                     r_estado   <= CALC;
                     r_div_cero <= 1'b0;
                  end
               end
            end
            CALC: begin
               r_r   <= w_r_sig;
               r_q   <= w_q_sig;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == '0) begin
                  r_estado   <= DONE;
                  r_valido   <= 1'b1;
                  r_cociente <= w_q_sig;
                  r_residuo  <= w_r_sig;
               end
            end
            DONE: begin
               r_valido <= 1'b0;
               r_listo  <= 1'b1;
               r_estado <= IDLE;
            end
            default: begin
               r_valido <= 1'b0;
               r_listo  <= 1'b1;
               r_estado <= IDLE;
            end
         endcase
      end
   end

   assign bus.listo    = r_listo;
   assign bus.valido   = r_valido;
   assign bus.cociente = r_cociente;
   assign bus.residuo  = r_residuo;
   assign bus.div_cero = r_div_cero;

endmodule : controlador_division
`default_nettype wire

// File: tb/tb_controlador_division.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_division
// Description : Directed self-checking bench for controlador_division (N=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_division;
   import pda_pkg::*;

   localparam int N = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   controlador_division_if #(.N(N)) bus ();

   controlador_division #(
      .N (N)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Single comparison point
   task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock, land just after the rising edge
   task automatic ciclo();
      @(posedge clk);
      #1;
   endtask

   // Issue one request from IDLE and check latency and results
   task automatic dividir(input logic [7:0] a, input logic [7:0] b, input int lat,
                          input logic [7:0] qe, input logic [7:0] re, input logic dz,
                          input string tag);
      int cyc;
      bus.start     = 1'b1;
      bus.dividendo = a;
      bus.divisor   = b;
      ciclo();
      bus.start     = 1'b0;
      bus.dividendo = 8'hA5;
      bus.divisor   = 8'h3C;
      verificar({tag, "_listo_cae"}, 32'(bus.listo), 32'd0);
      cyc = 1;
      while (!bus.valido && cyc < 40) begin
         ciclo();
         cyc++;
      end
      verificar({tag, "_latencia"}, 32'(cyc), 32'(lat));
      verificar({tag, "_cociente"}, 32'(bus.cociente), 32'(qe));
      verificar({tag, "_residuo"}, 32'(bus.residuo), 32'(re));
      verificar({tag, "_div_cero"}, 32'(bus.div_cero), 32'(dz));
      ciclo();
      verificar({tag, "_listo_vuelve"}, 32'(bus.listo), 32'd1);
      verificar({tag, "_valido_1ciclo"}, 32'(bus.valido), 32'd0);
   endtask

   initial begin
      int npulsos;
      int vcyc;
      bus.start     = 1'b0;
      bus.dividendo = '0;
      bus.divisor   = '0;

      // Reset state
      repeat (2) ciclo();
      verificar("rst_listo", 32'(bus.listo), 32'd1);
      verificar("rst_valido", 32'(bus.valido), 32'd0);
      verificar("rst_cociente", 32'(bus.cociente), 32'd0);
      verificar("rst_residuo", 32'(bus.residuo), 32'd0);
      verificar("rst_div_cero", 32'(bus.div_cero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ciclo();

      // Basic divisions
      dividir(8'd100, 8'd7,   9, 8'd14,  8'd2,  1'b0, "d100_7");
      dividir(8'd255, 8'd1,   9, 8'd255, 8'd0,  1'b0, "d255_1");
      dividir(8'd5,   8'd9,   9, 8'd0,   8'd5,  1'b0, "d5_9");
      dividir(8'd200, 8'd200, 9, 8'd1,   8'd0,  1'b0, "d200_200");

      // Divide by zero and the clearing of div_cero
      dividir(8'd77,  8'd0,   1, 8'd255, 8'd77, 1'b1, "d77_0");
      dividir(8'd10,  8'd3,   9, 8'd3,   8'd1,  1'b0, "d10_3");

      // Requests during CALC and DONE are ignored
      bus.start     = 1'b1;
      bus.dividendo = 8'd100;
      bus.divisor   = 8'd7;
      ciclo();
      npulsos = 0;
      vcyc    = 0;
      for (int c = 1; c <= 14; c++) begin
         if (bus.valido) begin
            npulsos++;
            vcyc = c;
            verificar("ign_cociente", 32'(bus.cociente), 32'd14);
            verificar("ign_residuo", 32'(bus.residuo), 32'd2);
         end
         bus.start     = (c == 3 || c == 9);
         bus.dividendo = 8'd50;
         bus.divisor   = 8'd5;
         ciclo();
      end
      bus.start = 1'b0;
      verificar("ign_pulsos", 32'(npulsos), 32'd1);
      verificar("ign_ciclo_valido", 32'(vcyc), 32'd9);
      verificar("ign_listo", 32'(bus.listo), 32'd1);
      verificar("ign_cociente_fijo", 32'(bus.cociente), 32'd14);
      verificar("ign_residuo_fijo", 32'(bus.residuo), 32'd2);
      dividir(8'd50, 8'd5, 9, 8'd10, 8'd0, 1'b0, "d50_5");

      // Asynchronous reset in the middle of an operation
      bus.start     = 1'b1;
      bus.dividendo = 8'd100;
      bus.divisor   = 8'd7;
      ciclo();
      bus.start = 1'b0;
      repeat (3) ciclo();
      #3;
      rst_n = 1'b0;
      #1;
      verificar("arst_listo", 32'(bus.listo), 32'd1);
      verificar("arst_valido", 32'(bus.valido), 32'd0);
      verificar("arst_cociente", 32'(bus.cociente), 32'd0);
      verificar("arst_residuo", 32'(bus.residuo), 32'd0);
      repeat (2) ciclo();
      @(negedge clk);
      rst_n = 1'b1;
      npulsos = 0;
      for (int c = 0; c < 12; c++) begin
         ciclo();
         if (bus.valido) npulsos++;
      end
      verificar("arst_sin_valido", 32'(npulsos), 32'd0);
      dividir(8'd9, 8'd2, 9, 8'd4, 8'd1, 1'b0, "d9_2");

      // start held high: one result every N+2 cycles
      bus.start     = 1'b1;
      bus.dividendo = 8'd60;
      bus.divisor   = 8'd7;
      npulsos = 0;
      for (int c = 1; c <= 40; c++) begin
         ciclo();
         if (bus.valido) begin
            verificar("cont_ciclo", 32'(c), 32'(9 + 10 * npulsos));
            verificar("cont_cociente", 32'(bus.cociente), 32'd8);
            verificar("cont_residuo", 32'(bus.residuo), 32'd4);
            npulsos++;
         end
      end
      bus.start = 1'b0;
      verificar("cont_pulsos", 32'(npulsos), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_controlador_division
`default_nettype wire
